// File: rtl/pe_pragmatic_ctrl_pkg.sv
// Shared types for the Pragmatic bit-serial processing element.
// Holds the control state encoding and the accumulator width rule.
package pe_pragmatic_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_COMPUTE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  // Worst case: VEC_LENGTH terms of (2^DW-1)*(2^(DW-1)-1), plus a sign bit.
  function automatic int acc_width(input int dw, input int vl);
    return 2 * dw + $clog2(vl) + 1;
  endfunction

endpackage

// File: rtl/pragmatic_shift_add.sv
// Per-cycle partial sum: each valid lane shifts its activation by its essential-bit
// offset, applies the weight sign, and all lanes are summed combinationally.
module pragmatic_shift_add
  import pe_pragmatic_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LENGTH = 8,
  parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, VEC_LENGTH),
  parameter int OFF_W      = $clog2(DATA_WIDTH)
) (
  input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] i_act,
  input  logic [VEC_LENGTH-1:0][OFF_W-1:0]      i_off,
  input  logic [VEC_LENGTH-1:0]                 i_sign,
  input  logic [VEC_LENGTH-1:0]                 i_vld,
  output logic signed [ACC_WIDTH-1:0]           o_psum
);

  localparam int PW = 2 * DATA_WIDTH - 1;

  logic [VEC_LENGTH-1:0][PW-1:0]  w_shift;
  logic signed [ACC_WIDTH-1:0]    w_term [VEC_LENGTH];

  always_comb begin
    w_shift = '0;
    o_psum  = '0;
    for (int i = 0; i < VEC_LENGTH; i++) begin
      w_term[i]  = '0;
      w_shift[i] = PW'(i_act[i]) << i_off[i];
      if (i_vld[i]) begin
        w_term[i] = i_sign[i] ? -$signed(ACC_WIDTH'(w_shift[i]))
                              :  $signed(ACC_WIDTH'(w_shift[i]));
      end
      o_psum = o_psum + w_term[i];
    end
  end

endmodule

// File: rtl/pe_pragmatic_ctrl.sv
// Bit-serial PE: accumulates the signed dot product of one weight vector with a
// latched activation vector, one essential bit per cycle, and hands off via valid/ready.
module pe_pragmatic_ctrl
  import pe_pragmatic_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LENGTH = 8,
  parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, VEC_LENGTH),
  parameter int OFF_W      = $clog2(DATA_WIDTH)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] act_in,
  input  logic                                  act_valid,
  output logic                                  act_ready,
  output logic                                  wen_rf,
  output logic                                  en_comp,
  input  logic [VEC_LENGTH-1:0][OFF_W-1:0]      oneffset,
  input  logic [VEC_LENGTH-1:0]                 sign_oneffset,
  input  logic [VEC_LENGTH-1:0]                 val_oneffset,
  output logic signed [ACC_WIDTH-1:0]           result,
  output logic                                  result_valid,
  input  logic                                  result_ready
);

  localparam int              CNT_W   = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_WIDTH - 1);

  state_t                                r_state;
  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] r_act;
  logic signed [ACC_WIDTH-1:0]           r_acc;
  logic signed [ACC_WIDTH-1:0]           r_result;
  logic [CNT_W-1:0]                      r_cnt;
  logic                                  r_result_valid;
  logic                                  r_en_comp;

  logic signed [ACC_WIDTH-1:0]           w_psum;
  logic signed [ACC_WIDTH-1:0]           w_acc_next;
  logic                                  w_accept;
  logic                                  w_last;

  pragmatic_shift_add #(
    .DATA_WIDTH (DATA_WIDTH),
    .VEC_LENGTH (VEC_LENGTH),
    .ACC_WIDTH  (ACC_WIDTH),
    .OFF_W      (OFF_W)
  ) u_shift_add (
    .i_act  (r_act),
    .i_off  (oneffset),
    .i_sign (sign_oneffset),
    .i_vld  (val_oneffset),
    .o_psum (w_psum)
  );

  assign act_ready    = (r_state == S_IDLE) | ((r_state == S_DONE) & result_ready);
  assign w_accept     = act_valid & act_ready;
  assign wen_rf       = w_accept;
  assign en_comp      = r_en_comp;
  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign w_acc_next   = r_acc + w_psum;
  // The counter guard only bounds a misbehaving scheduler; normal jobs end on an all-invalid cycle.
  assign w_last       = ~(|val_oneffset) | (r_cnt == CNT_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_act          <= '0;
      r_acc          <= '0;
      r_result       <= '0;
      r_cnt          <= '0;
      r_result_valid <= 1'b0;
      r_en_comp      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_act          <= act_in;
            r_acc          <= '0;
            r_cnt          <= '0;
            r_result_valid <= 1'b0;
            r_en_comp      <= 1'b1;
            r_state        <= S_FETCH;
          end else if ((r_state == S_DONE) && result_ready) begin
            r_result_valid <= 1'b0;
            r_state        <= S_IDLE;
          end
        end
        S_FETCH: begin
          r_state <= S_COMPUTE;
        end
        S_COMPUTE: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_result       <= w_acc_next;
            r_result_valid <= 1'b1;
            r_en_comp      <= 1'b0;
            r_state        <= S_DONE;
          end
        end
        default: begin
          r_en_comp <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule
